// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-ported, registered-read memory between
// an instruction-fetch port and a data load/store port.
//   state  | meaning
//   IDLE   | waiting for a request; ready asserted to the round-robin winner
//   ACCESS | latched request drives memory address/data/write strobe
//   RESP   | response pulse to the granted port with memory read data
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_DEPTH  = 256,
  parameter int WORD_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic [1:0]        state;
  logic              last_grant;
  logic              lat_port;
  logic              lat_we;
  logic              lat_err;
  logic              idle;
  logic              grant_i;
  logic              grant_d;
  logic              in_resp;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;

  // Under contention the port that did not win last time is served.
  always_comb begin
    idle     = (state == IDLE);
    grant_d  = d_valid & (~i_valid | (last_grant == PORT_I));
    grant_i  = i_valid & ~grant_d;
    sel_addr = grant_d ? d_addr : i_addr;
    sel_err  = (sel_addr[WORD_SHIFT-1:0] != '0) ||
               ((sel_addr >> WORD_SHIFT) >= ADDR_W'(MEM_DEPTH));
  end

  assign i_ready = idle & grant_i;
  assign d_ready = idle & grant_d;
  assign busy    = ~idle;
  assign in_resp = (state == RESP);

  // Erroneous stores never reach memory.
  assign mem_rw = (state == ACCESS) & lat_we & ~lat_err;

  assign i_resp_valid = in_resp & (lat_port == PORT_I);
  assign i_err        = i_resp_valid & lat_err;
  assign i_rdata      = (i_resp_valid & ~lat_err) ? mem_rdata : '0;

  assign d_resp_valid = in_resp & (lat_port == PORT_D);
  assign d_err        = d_resp_valid & lat_err;
  assign d_rdata      = (d_resp_valid & ~lat_err & ~lat_we) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_D;
      lat_port   <= PORT_I;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i | grant_d) begin
            lat_port   <= grant_d;
            lat_we     <= grant_d & d_we;
            lat_err    <= sel_err;
            mem_addr   <= sel_addr >> WORD_SHIFT;
            mem_wdata  <= grant_d ? d_wdata : '0;
            last_grant <= grant_d;
            state      <= ACCESS;
          end
        end
        ACCESS:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed plan scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  logic              d_valid;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .WORD_SHIFT(2)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 ^ (64'(i) * 64'h0001_0003_0005_0007);
  endfunction

  // SOC memory: registered read, write on mem_rw; unwritten words hold pat().
  logic [DATA_W-1:0] soc_mem [DEPTH];
  logic              soc_wr  [DEPTH];

  function automatic logic [DATA_W-1:0] soc_read(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_W'(DEPTH)) return '0;
    if (soc_wr[a[7:0]] === 1'b1) return soc_mem[a[7:0]];
    return pat(int'(a[7:0]));
  endfunction

  always @(posedge clk) begin
    if (mem_rw === 1'b1 && mem_addr < ADDR_W'(DEPTH)) begin
      soc_mem[mem_addr[7:0]] <= mem_wdata;
      soc_wr[mem_addr[7:0]]  <= 1'b1;
    end
    mem_rdata <= soc_read(mem_addr);
  end

  // Reference model: phase 0 idle, 1 memory access, 2 response.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ph     = 0;
  int                m_last = 1;
  int                m_port = 0;
  logic              m_we   = 1'b0;
  logic              m_err  = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [ADDR_W-1:0] ia,
                      input logic dv, input logic dwe, input logic [ADDR_W-1:0] da,
                      input logic [DATA_W-1:0] dwd, output int win);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_rd;
    @(negedge clk);
    reset = rst; i_valid = iv; i_addr = ia;
    d_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    win = -1;
    if (ph == 0) begin
      if (iv && dv)  win = (m_last == 1) ? 0 : 1;
      else if (iv)   win = 0;
      else if (dv)   win = 1;
    end
    exp_rd = (ph == 2 && !m_err && !m_we) ? m_rdata : '0;
    chk("i_ready", 64'(i_ready), 64'(win == 0));
    chk("d_ready", 64'(d_ready), 64'(win == 1));
    chk("busy", 64'(busy), 64'(ph != 0));
    chk("mem_rw", 64'(mem_rw), 64'(ph == 1 && m_we && !m_err));
    chk("mem_addr", mem_addr, m_addr);
    if (ph == 1) chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_resp_valid", 64'(i_resp_valid), 64'(ph == 2 && m_port == 0));
    chk("d_resp_valid", 64'(d_resp_valid), 64'(ph == 2 && m_port == 1));
    chk("i_err", 64'(i_err), 64'(ph == 2 && m_port == 0 && m_err));
    chk("d_err", 64'(d_err), 64'(ph == 2 && m_port == 1 && m_err));
    chk("i_rdata", i_rdata, (m_port == 0) ? exp_rd : '0);
    chk("d_rdata", d_rdata, (m_port == 1) ? exp_rd : '0);

    if (rst) begin
      // A store interrupted in its access cycle still lands in memory.
      if (ph == 1 && m_we && !m_err) ref_mem[m_addr[7:0]] = m_wdata;
      ph = 0; m_last = 1; m_addr = '0; win = -1;
    end else begin
      case (ph)
        0: if (win >= 0) begin
          a       = (win == 1) ? da : ia;
          m_port  = win;
          m_we    = (win == 1) && dwe;
          m_err   = (a % 4 != 0) || (a / 4 >= 64'(DEPTH));
          m_addr  = a / 4;
          m_wdata = (win == 1) ? dwd : '0;
          m_rdata = m_err ? '0 : ref_mem[m_addr[7:0]];
          m_last  = win;
          ph      = 1;
        end
        1: begin
          if (m_we && !m_err) ref_mem[m_addr[7:0]] = m_wdata;
          ph = 2;
        end
        default: ph = 0;
      endcase
    end
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return ADDR_W'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
    if (r == 1) return ADDR_W'($urandom_range(256, 100000)) << 2;
    return ADDR_W'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    int w;
    logic              r_iv, r_dv, r_dwe, r_rst;
    logic [ADDR_W-1:0] r_ia, r_da;
    logic [DATA_W-1:0] r_dwd;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    reset = 1'b1; i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mem_wdata_reset", mem_wdata, '0);

    // Single fetch from 0x8, then idle through the response.
    step(0, 1, 64'h8, 0, 0, '0, '0, w);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);

    // Store 0xDEADBEEF at 0x10, then load it back.
    step(0, 0, '0, 1, 1, 64'h10, 64'hDEADBEEF, w);
    repeat (2) step(0, 0, '0, 0, 0, '0, '0, w);
    step(0, 0, '0, 1, 0, 64'h10, '0, w);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);

    // Contention: both ports held valid for four grants.
    repeat (12) step(0, 1, 64'h20, 1, 0, 64'h10, '0, w);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);

    // Misaligned store and out-of-range fetch.
    step(0, 0, '0, 1, 1, 64'h6, 64'h1234, w);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);
    step(0, 1, 64'h400, 0, 0, '0, '0, w);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);

    // Reset during the access cycle of a load, then a normal request.
    step(0, 0, '0, 1, 0, 64'h10, '0, w);
    step(1, 0, '0, 0, 0, '0, '0, w);
    repeat (2) step(0, 0, '0, 0, 0, '0, '0, w);
    step(0, 1, 64'h10, 0, 0, '0, '0, w);
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);

    // Randomized traffic; requests stay stable until accepted unless dropped.
    r_iv = 0; r_dv = 0; r_dwe = 0; r_ia = '0; r_da = '0; r_dwd = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!r_iv) begin
        r_iv = ($urandom_range(0, 2) != 0);
        r_ia = rnd_addr();
      end else if ($urandom_range(0, 19) == 0) r_iv = 0;
      if (!r_dv) begin
        r_dv  = ($urandom_range(0, 2) != 0);
        r_dwe = $urandom_range(0, 1) == 1;
        r_da  = rnd_addr();
        r_dwd = {$urandom(), $urandom()};
      end else if ($urandom_range(0, 19) == 0) r_dv = 0;
      r_rst = ($urandom_range(0, 99) == 0);
      step(r_rst, r_iv, r_ia, r_dv, r_dwe, r_da, r_dwd, w);
      if (w == 0) r_iv = 0;
      if (w == 1) r_dv = 0;
    end
    repeat (3) step(0, 0, '0, 0, 0, '0, '0, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
